ntt_coef_loader: RTL and testbench
==================================

Name: ntt_coef_loader

Overview:
Upstream feed stage for the NTT core. Drains the two 32-bit input FIFOs (A = even-index lane, B = odd-index lane), unpacks each word into an 8-bit coefficient address (bits 23:16) and a 16-bit coefficient (bits 15:0), and writes both coefficients per cycle into the core's dual-port coefficient RAM. Counts loaded coefficients, checks address ordering, and pulses in_done when a full polynomial is resident.

Parameters:
N, 256, coefficients per polynomial; even, N/2 pops per load, max 2**ADDR_W
DATA_W, 16, coefficient width
ADDR_W, 8, coefficient address width

Ports:
clk  in  1  system clock; FIFO read side and RAM share this clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin a load; sampled in IDLE only
fifo_a_rd_data  in  32  FIFO A read data, valid the cycle after fifo_rd_req
fifo_a_empty  in  1  FIFO A empty
fifo_b_rd_data  in  32  FIFO B read data, valid the cycle after fifo_rd_req
fifo_b_empty  in  1  FIFO B empty
fifo_rd_req  out  1  pop one word from each FIFO (common to A and B)
ram_we  out  1  write strobe, both ports
ram_addr_a  out  ADDR_W  port A address
ram_din_a  out  DATA_W  port A data
ram_addr_b  out  ADDR_W  port B address
ram_din_b  out  DATA_W  port B data
busy  out  1  high in LOAD and DRAIN
in_done  out  1  one-cycle pulse, load complete
addr_err  out  1  sticky; address field out of sequence
load_count  out  ADDR_W+1  coefficients written so far in current load

Behaviour:
- Reset: state IDLE; fifo_rd_req, ram_we, busy, in_done, addr_err = 0; ram_addr_*, ram_din_*, load_count = 0; internal issue/write counters = 0. Reset mid-load abandons the load; FIFO contents are not flushed (host asserts FIFO aclr).
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE: start=1 -> LOAD; clears load_count, issue counter, addr_err. start in any other state ignored.
- LOAD: fifo_rd_req = (state==LOAD) & !fifo_a_empty & !fifo_b_empty & (issued < N/2); combinational, so back-to-back pops give 1 pair/cycle. When issued reaches N/2 -> DRAIN.
- Pipeline: pop at edge ending cycle t; rd_data valid in cycle t+1; registered at end of t+1; ram_we=1 during cycle t+2 with ram_addr_a=A[23:16], ram_din_a=A[15:0], ram_addr_b=B[23:16], ram_din_b=B[15:0]. Latency rd_req -> ram_we = 2 cycles. Bits 31:24 ignored.
- load_count += 2 on each ram_we cycle (registered, visible the cycle after the write).
- Address check on each captured pair k (0-based): expected A addr = 2k, B addr = 2k+1. Mismatch sets addr_err (sticky until next start); write still uses received addresses.
- DRAIN: wait until the write of pair N/2-1 has been issued (pipeline empty) -> DONE.
- DONE: in_done=1 for exactly one cycle, busy=0, then IDLE. load_count holds N until next start.
- One FIFO empty, other not: no pop; stall with no partial reads. Empty mid-load: ram_we gaps correspond 1:1 to rd_req gaps.
- Never pops beyond N/2 in a load, even if FIFOs hold more data.
- start asserted on the in_done cycle: ignored (DONE is not IDLE); accepted the following cycle.

Test Plan:
- N=8, both FIFOs prefilled with addrs A 0,2,4,6 / B 1,3,5,7, data 0x1000+addr; pulse start -> rd_req high 4 consecutive cycles, ram_we 4 consecutive cycles starting 2 cycles after first rd_req, in_done pulse once, load_count=8, addr_err=0.
- Same load, FIFO B empty for 3 cycles after second pop -> rd_req low 3 cycles, ram_we has matching 3-cycle gap, final RAM contents identical, in_done still single pulse.
- FIFOs hold 6 pairs, N=8 -> exactly 4 pops; 2 pairs remain in FIFOs; fifo_rd_req stays 0 in DONE/IDLE.
- Pair 2 carries A addr 0x05 instead of 0x04 -> addr_err=1 the cycle after capture, RAM written at 0x05, load completes, in_done pulses; next start clears addr_err.
- rst asserted after 2 pops -> all outputs 0 immediately (async), state IDLE, no further ram_we; new start with refilled FIFOs completes normally.
- start pulsed while busy and on the in_done cycle -> ignored; no second load until start after return to IDLE.

Source files
------------

// File: rtl/ntt_coef_loader.sv
// Feed stage for the NTT core: pops paired words from the even/odd lane FIFOs,
// unpacks address/coefficient fields and writes both lanes into the dual-port coefficient RAM.
module ntt_coef_loader #(
    parameter int N      = 256,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [31:0]       i_fifo_a_rd_data,
    input  logic              i_fifo_a_empty,
    input  logic [31:0]       i_fifo_b_rd_data,
    input  logic              i_fifo_b_empty,
    output logic              o_fifo_rd_req,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr_a,
    output logic [DATA_W-1:0] o_ram_din_a,
    output logic [ADDR_W-1:0] o_ram_addr_b,
    output logic [DATA_W-1:0] o_ram_din_b,
    output logic              o_busy,
    output logic              o_in_done,
    output logic              o_addr_err,
    output logic [ADDR_W:0]   o_load_count
);

    localparam logic [ADDR_W-1:0] HALF    = ADDR_W'(N / 2);
    localparam logic [ADDR_W-1:0] HALF_M1 = ADDR_W'(N / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_issued;
    logic [ADDR_W-1:0]   r_cap_pairs;
    logic [ADDR_W-1:0]   r_wr_pairs;
    logic                r_rd_vld;
    logic                r_we;
    logic                r_addr_err;
    logic [ADDR_W:0]     r_load_count;
    logic [ADDR_W-1:0]   r_addr [2];
    logic [DATA_W-1:0]   r_din  [2];

    logic [31:0]         w_word [2];
    logic [1:0]          w_addr_bad;
    logic [ADDR_W-1:0]   w_exp_base;
    logic                w_rd_req;
    logic                w_busy;
    logic                w_done;
    logic                w_start_load;

    assign w_word[0]    = i_fifo_a_rd_data;
    assign w_word[1]    = i_fifo_b_rd_data;
    assign w_exp_base   = {r_cap_pairs[ADDR_W-2:0], 1'b0};
    assign w_start_load = (r_state == S_IDLE) && i_start;

    // Lane gi of pair k must carry address 2k+gi.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane_chk
            assign w_addr_bad[gi] = (w_word[gi][16 +: ADDR_W] != (w_exp_base | ADDR_W'(gi)));
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_rd_req     = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_busy   = 1'b1;
                w_rd_req = !i_fifo_a_empty && !i_fifo_b_empty && (r_issued < HALF);
                if (w_rd_req && (r_issued == HALF_M1)) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (r_we && (r_wr_pairs == HALF_M1)) w_state_next = S_DONE;
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_issued     <= '0;
            r_cap_pairs  <= '0;
            r_wr_pairs   <= '0;
            r_rd_vld     <= 1'b0;
            r_we         <= 1'b0;
            r_addr_err   <= 1'b0;
            r_load_count <= '0;
        end else begin
            r_state  <= w_state_next;
            r_rd_vld <= w_rd_req;
            r_we     <= r_rd_vld;
            if (w_start_load) begin
                r_issued     <= '0;
                r_cap_pairs  <= '0;
                r_wr_pairs   <= '0;
                r_addr_err   <= 1'b0;
                r_load_count <= '0;
            end else begin
                if (w_rd_req) r_issued <= r_issued + 1'b1;
                if (r_rd_vld) begin
                    r_cap_pairs <= r_cap_pairs + 1'b1;
                    if (|w_addr_bad) r_addr_err <= 1'b1;
                end
                if (r_we) begin
                    r_wr_pairs   <= r_wr_pairs + 1'b1;
                    r_load_count <= r_load_count + (ADDR_W+1)'(2);
                end
            end
        end
    end

    // Received addresses are written as-is even when out of sequence.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int li = 0; li < 2; li++) begin
                r_addr[li] <= '0;
                r_din[li]  <= '0;
            end
        end else if (r_rd_vld) begin
            for (int li = 0; li < 2; li++) begin
                r_addr[li] <= w_word[li][16 +: ADDR_W];
                r_din[li]  <= w_word[li][DATA_W-1:0];
            end
        end
    end

    assign o_fifo_rd_req = w_rd_req;
    assign o_ram_we      = r_we;
    assign o_ram_addr_a  = r_addr[0];
    assign o_ram_din_a   = r_din[0];
    assign o_ram_addr_b  = r_addr[1];
    assign o_ram_din_b   = r_din[1];
    assign o_busy        = w_busy;
    assign o_in_done     = w_done;
    assign o_addr_err    = r_addr_err;
    assign o_load_count  = r_load_count;

endmodule

// File: tb/tb_ntt_coef_loader.sv
// Bench for ntt_coef_loader with N=8: FIFO models, a write/handshake monitor,
// a table of pair vectors and directed multi-cycle sequences.
module tb_ntt_coef_loader;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a_data;
    logic [31:0] b_data;
    logic        a_empty, b_empty;
    logic        rd_req, ram_we, busy, in_done, addr_err;
    logic [7:0]  addr_a, addr_b;
    logic [15:0] din_a, din_b;
    logic [8:0]  load_count;

    ntt_coef_loader #(.N(N), .DATA_W(16), .ADDR_W(8)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_start          (start),
        .i_fifo_a_rd_data (a_data),
        .i_fifo_a_empty   (a_empty),
        .i_fifo_b_rd_data (b_data),
        .i_fifo_b_empty   (b_empty),
        .o_fifo_rd_req    (rd_req),
        .o_ram_we         (ram_we),
        .o_ram_addr_a     (addr_a),
        .o_ram_din_a      (din_a),
        .o_ram_addr_b     (addr_b),
        .o_ram_din_b      (din_b),
        .o_busy           (busy),
        .o_in_done        (in_done),
        .o_addr_err       (addr_err),
        .o_load_count     (load_count)
    );

    always #5 clk = ~clk;

    // FIFO models: read data appears the cycle after a pop.
    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    int          wr_a = 0, wr_b = 0, rd_a = 0, rd_b = 0;
    logic        stall_b = 1'b0;
    logic        flush = 1'b0;

    assign a_empty = (rd_a == wr_a);
    assign b_empty = (rd_b == wr_b) || stall_b;

    always @(posedge clk) begin
        if (flush) begin
            rd_a <= wr_a;
            rd_b <= wr_b;
        end else if (rd_req) begin
            a_data <= mem_a[rd_a % 64];
            b_data <= mem_b[rd_b % 64];
            rd_a   <= rd_a + 1;
            rd_b   <= rd_b + 1;
        end
    end

    // Monitor sampled on the falling edge.
    int   cyc = 0, n_rq = 0, n_we = 0, n_done = 0, n_busy = 0;
    bit   rq_hist [4096];
    bit   we_hist [4096];
    logic [7:0]  log_aa [256];
    logic [7:0]  log_ab [256];
    logic [15:0] log_da [256];
    logic [15:0] log_db [256];
    bit          log_err [256];

    initial begin
        forever begin
            @(negedge clk);
            if (cyc < 4096) begin
                rq_hist[cyc] = rd_req;
                we_hist[cyc] = ram_we;
            end
            if (ram_we && n_we < 256) begin
                log_aa[n_we]  = addr_a;
                log_da[n_we]  = din_a;
                log_ab[n_we]  = addr_b;
                log_db[n_we]  = din_b;
                log_err[n_we] = addr_err;
            end
            if (ram_we) n_we++;
            if (rd_req) n_rq++;
            if (in_done) n_done++;
            if (busy) n_busy++;
            cyc++;
        end
    end

    typedef struct {
        logic [31:0] a_word;
        logic [31:0] b_word;
        logic [7:0]  ea;
        logic [15:0] da;
        logic [7:0]  eb;
        logic [15:0] db;
    } vec_t;
    vec_t tbl [4];

    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        mem_a[wr_a % 64] = a;
        mem_b[wr_b % 64] = b;
        wr_a++;
        wr_b++;
    endtask

    task automatic push_table();
        for (int i = 0; i < 4; i++) push(tbl[i].a_word, tbl[i].b_word);
    endtask

    task automatic start_pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic do_flush();
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0);
        for (int k = 0; k < 200 && n_done == d0; k++) @(posedge clk);
        check({name, "_done_seen"}, 64'(n_done > d0), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string name, input int base);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_pair%0d", name, i),
                  {log_aa[base+i], log_da[base+i], log_ab[base+i], log_db[base+i]},
                  {tbl[i].ea, tbl[i].da, tbl[i].eb, tbl[i].db});
    endtask

    // Each write cycle must trail a pop cycle by exactly two cycles.
    task automatic check_shift(input string name, input int from_c, input int to_c);
        int m = 0;
        for (int c = from_c; c <= to_c; c++)
            if (we_hist[c+2] != rq_hist[c]) m++;
        check(name, m, 0);
    endtask

    task automatic rq_span(input int from_c, input int to_c, output int first, output int last);
        first = -1;
        last  = -1;
        for (int c = from_c; c <= to_c; c++)
            if (rq_hist[c]) begin
                if (first < 0) first = c;
                last = c;
            end
    endtask

    int c0, q0, w0, d0, b0, f, l, wsnap, qsnap;

    initial begin
        tbl[0] = '{32'hA5_00_1000, 32'h5A_01_1001, 8'h00, 16'h1000, 8'h01, 16'h1001};
        tbl[1] = '{32'hFF_02_1002, 32'h00_03_1003, 8'h02, 16'h1002, 8'h03, 16'h1003};
        tbl[2] = '{32'h12_04_1004, 32'h34_05_1005, 8'h04, 16'h1004, 8'h05, 16'h1005};
        tbl[3] = '{32'hC3_06_1006, 32'h3C_07_1007, 8'h06, 16'h1006, 8'h07, 16'h1007};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_held_outputs", {rd_req, ram_we, busy, in_done, addr_err, load_count}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_outputs", {rd_req, ram_we, busy, in_done, addr_err, load_count}, 0);
        check("reset_ram_bus", {addr_a, din_a, addr_b, din_b}, 0);

        // Basic load, back-to-back
        push_table();
        @(posedge clk); #1;
        check("idle_no_pop", rd_req, 0);
        c0 = cyc; q0 = n_rq; w0 = n_we; d0 = n_done; b0 = n_busy;
        start_pulse();
        wait_done("basic", d0);
        check("basic_pops", n_rq - q0, 4);
        check("basic_writes", n_we - w0, 4);
        check("basic_done_once", n_done - d0, 1);
        check("basic_busy_cycles", n_busy - b0, 6);
        check("basic_load_count", load_count, 8);
        check("basic_addr_err", addr_err, 0);
        rq_span(c0, cyc - 1, f, l);
        check("basic_pop_span", l - f, 3);
        check_shift("basic_we_latency", c0, cyc - 3);
        check_log("basic", w0);

        // FIFO B empty for three cycles after the second pop
        push_table();
        c0 = cyc; q0 = n_rq; w0 = n_we; d0 = n_done;
        start_pulse();
        for (int k = 0; k < 50 && (n_rq - q0) < 2; k++) begin
            @(posedge clk); #1;
        end
        stall_b = 1'b1;
        repeat (3) @(posedge clk);
        #1 stall_b = 1'b0;
        wait_done("stall", d0);
        check("stall_pops", n_rq - q0, 4);
        check("stall_writes", n_we - w0, 4);
        check("stall_done_once", n_done - d0, 1);
        rq_span(c0, cyc - 1, f, l);
        check("stall_pop_span", l - f, 6);
        check_shift("stall_we_gaps", c0, cyc - 3);
        check_log("stall", w0);
        check("stall_load_count", load_count, 8);

        // Six pairs available, only four consumed
        push_table();
        push(32'h00_08_1008, 32'h00_09_1009);
        push(32'h00_0A_100A, 32'h00_0B_100B);
        q0 = n_rq; d0 = n_done;
        start_pulse();
        wait_done("over", d0);
        repeat (5) @(posedge clk);
        #1;
        check("over_pops", n_rq - q0, 4);
        check("over_left_a", wr_a - rd_a, 2);
        check("over_left_b", wr_b - rd_b, 2);
        check("over_idle_no_pop", rd_req, 0);
        do_flush();

        // Pair 2 lane A carries address 0x05
        push(tbl[0].a_word, tbl[0].b_word);
        push(tbl[1].a_word, tbl[1].b_word);
        push(32'h3C_05_1004, tbl[2].b_word);
        push(tbl[3].a_word, tbl[3].b_word);
        w0 = n_we; d0 = n_done;
        start_pulse();
        wait_done("aerr", d0);
        check("aerr_err_flags", {log_err[w0], log_err[w0+1], log_err[w0+2], log_err[w0+3]}, 4'b0011);
        check("aerr_wr_addr", {log_aa[w0+2], log_da[w0+2]}, {8'h05, 16'h1004});
        check("aerr_sticky", addr_err, 1);
        check("aerr_load_count", load_count, 8);
        push_table();
        d0 = n_done;
        start_pulse();
        check("aerr_cleared_by_start", addr_err, 0);
        wait_done("aerr_next", d0);
        check("aerr_next_clean", addr_err, 0);

        // Asynchronous reset after two pops
        push_table();
        q0 = n_rq;
        start_pulse();
        for (int k = 0; k < 50 && (n_rq - q0) < 2; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("arst_ctrl", {rd_req, ram_we, busy, in_done, addr_err}, 0);
        check("arst_data", {load_count, addr_a, din_a, addr_b, din_b}, 0);
        @(posedge clk); #1 rst = 1'b0;
        wsnap = n_we; qsnap = n_rq;
        repeat (6) @(posedge clk);
        #1;
        check("arst_no_writes", n_we - wsnap, 0);
        check("arst_no_pops", n_rq - qsnap, 0);
        do_flush();
        push_table();
        w0 = n_we; d0 = n_done;
        start_pulse();
        wait_done("arst_reload", d0);
        check("arst_reload_count", load_count, 8);
        check_log("arst_reload", w0);

        // start while busy and on the in_done cycle is ignored
        push_table();
        push_table();
        q0 = n_rq; d0 = n_done; w0 = n_we;
        start_pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 50 && !in_done; k++) begin
            @(posedge clk); #1;
        end
        check("ign_in_done_reached", in_done, 1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("ign_single_load_pops", n_rq - q0, 4);
        check("ign_single_done", n_done - d0, 1);
        check("ign_fifo_left", wr_a - rd_a, 4);
        start_pulse();
        wait_done("ign_second", d0 + 1);
        check("ign_second_pops", n_rq - q0, 8);
        check("ign_fifo_empty", wr_a - rd_a, 0);
        check_log("ign_second", w0 + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
